// File: rtl/cdc_src_fifo.sv
// Valid/ready FIFO in the source clock domain ahead of cdc_2phase_src.
// It absorbs bursts while the slow handshake crossing drains one item per round trip.
module cdc_src_fifo #(
  parameter type         T            = logic,
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  T                 data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output T                 data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2) begin : g_depth_check
    $error("cdc_src_fifo: DEPTH must be at least 2");
  end

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] usage_q;

  logic push, pop, bypass, do_write, do_read;

  // Explicit wrap keeps non-power-of-two depths inside the storage array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign usage_o = usage_q;
  assign full_o  = (usage_q == DEPTH_CNT);
  assign empty_o = (usage_q == '0);

  // Upstream ready never looks at ready_i, so no combinational path back through the FIFO.
  assign ready_o = !full_o && !flush_i;

  if (FALL_THROUGH) begin : g_fall_through
    assign valid_o = (!empty_o || valid_i) && !flush_i;
    assign data_o  = empty_o ? data_i : mem[rd_ptr_q];
  end else begin : g_registered
    assign valid_o = !empty_o && !flush_i;
    assign data_o  = mem[rd_ptr_q];
  end

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  // An item forwarded straight through an empty fall-through FIFO never touches storage.
  assign bypass   = FALL_THROUGH && empty_o && push && pop;
  assign do_write = push && !bypass;
  assign do_read  = pop && !bypass;

  // NOTE: storage carries a reset so data_o is a defined '0 out of reset; flush leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (do_write) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_read)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_write, do_read})
        2'b10:   usage_q <= usage_q + CNT_W'(1);
        2'b01:   usage_q <= usage_q - CNT_W'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_src_fifo.sv
// Bench for cdc_src_fifo: three instances (DEPTH=4, DEPTH=3, DEPTH=4 fall-through)
// checked every cycle against a queue-based model of the FIFO contract.
module tb_cdc_src_fifo;

  localparam int N_DUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       flush_a   [N_DUT];
  logic       valid_a   [N_DUT];
  logic       rdy_a     [N_DUT];
  logic [7:0] din_a     [N_DUT];
  logic [7:0] dout_a    [N_DUT];
  logic       ready_o_a [N_DUT];
  logic       valid_o_a [N_DUT];
  logic       full_a    [N_DUT];
  logic       empty_a   [N_DUT];
  logic [2:0] usage_a   [N_DUT];
  logic [2:0] usage_d4, usage_ft;
  logic [1:0] usage_d3;

  assign usage_a[0] = usage_d4;
  assign usage_a[1] = {1'b0, usage_d3};
  assign usage_a[2] = usage_ft;

  cdc_src_fifo #(.T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b0)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a[0]),
    .data_i(din_a[0]), .valid_i(valid_a[0]), .ready_o(ready_o_a[0]),
    .data_o(dout_a[0]), .valid_o(valid_o_a[0]), .ready_i(rdy_a[0]),
    .usage_o(usage_d4), .full_o(full_a[0]), .empty_o(empty_a[0])
  );

  cdc_src_fifo #(.T(logic [7:0]), .DEPTH(3), .FALL_THROUGH(1'b0)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a[1]),
    .data_i(din_a[1]), .valid_i(valid_a[1]), .ready_o(ready_o_a[1]),
    .data_o(dout_a[1]), .valid_o(valid_o_a[1]), .ready_i(rdy_a[1]),
    .usage_o(usage_d3), .full_o(full_a[1]), .empty_o(empty_a[1])
  );

  cdc_src_fifo #(.T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b1)) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a[2]),
    .data_i(din_a[2]), .valid_i(valid_a[2]), .ready_o(ready_o_a[2]),
    .data_o(dout_a[2]), .valid_o(valid_o_a[2]), .ready_i(rdy_a[2]),
    .usage_o(usage_ft), .full_o(full_a[2]), .empty_o(empty_a[2])
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cur   = 0;
  logic [7:0] model_q [$];
  bit         last_push, last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (dut %0d) observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N_DUT; i++) begin
      valid_a[i] = 1'b0;
      rdy_a[i]   = 1'b0;
      flush_a[i] = 1'b0;
      din_a[i]   = 8'h00;
    end
  endtask

  // One clock cycle on the current DUT: drive, compare at the falling edge, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    int         depth, used;
    bit         ft, e_empty, e_full, e_ready, e_valid, push, pop;
    logic [7:0] e_data;
    depth = (cur == 1) ? 3 : 4;
    ft    = (cur == 2);
    valid_a[cur] = v;
    din_a[cur]   = d;
    rdy_a[cur]   = r;
    flush_a[cur] = f;
    @(negedge clk);
    used    = model_q.size();
    e_empty = (used == 0);
    e_full  = (used == depth);
    e_ready = !e_full && !f;
    e_valid = (!e_empty || (ft && v)) && !f;
    e_data  = e_empty ? d : model_q[0];
    check("usage",   32'(usage_a[cur]),   32'(used));
    check("empty",   32'(empty_a[cur]),   32'(e_empty));
    check("full",    32'(full_a[cur]),    32'(e_full));
    check("ready_o", 32'(ready_o_a[cur]), 32'(e_ready));
    check("valid_o", 32'(valid_o_a[cur]), 32'(e_valid));
    if (e_valid) check("data_o", 32'(dout_a[cur]), 32'(e_data));
    push = v && e_ready;
    pop  = e_valid && r;
    if (f) begin
      model_q.delete();
    end else if (!(ft && e_empty && push && pop)) begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(d);
    end
    last_push = push;
    last_pop  = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (model_q.size() > 0 && guard < 50) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    check("drained_empty", 32'(empty_a[cur]), 32'd1);
  endtask

  // Downstream behaves like the CDC source: after each accepted item ready stays low for 4 cycles.
  task automatic cdc_run(input int n_items);
    int stall = 0;
    int sent  = 0;
    int guard = 0;
    while ((sent < n_items || model_q.size() > 0) && guard < 4000) begin
      logic v;
      v = (sent < n_items) ? logic'($urandom_range(0, 1)) : 1'b0;
      step(v, 8'($urandom), stall == 0, 1'b0);
      if (last_push) sent++;
      if (last_pop) stall = 4;
      else if (stall > 0) stall--;
      guard++;
    end
    check("cdc_items_sent", 32'(sent), 32'(n_items));
    check("cdc_end_empty", 32'(empty_a[cur]), 32'd1);
    idle_all();
  endtask

  initial begin
    idle_all();
    #12;
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      cur = i;
      check("rst_ready_o", 32'(ready_o_a[i]), 32'd1);
      check("rst_valid_o", 32'(valid_o_a[i]), 32'd0);
      check("rst_usage",   32'(usage_a[i]),   32'd0);
      check("rst_empty",   32'(empty_a[i]),   32'd1);
      check("rst_full",    32'(full_a[i]),    32'd0);
      check("rst_data_o",  32'(dout_a[i]),    32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill DEPTH=4 with the consumer stalled, then drain in order.
    cur = 0;
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'hA4, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("full_after_4", 32'(full_a[0]), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush with a concurrent push: the pushed byte must never appear.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    drain();
    cdc_run(200);

    // DEPTH=3 streaming: pointers wrap, usage settles at 1.
    cur = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    check("stream_usage", 32'(usage_a[1]), 32'd1);
    drain();
    idle_all();

    // Fall-through: zero latency when empty, stored path otherwise.
    cur = 2;
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    check("ft_bypass_usage", 32'(usage_a[2]), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h3D, 1'b1, 1'b0);
    drain();
    cdc_run(200);

    // Asynchronous reset in the middle of a burst.
    cur = 0;
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    idle_all();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_usage",   32'(usage_a[0]),   32'd0);
    check("arst_empty",   32'(empty_a[0]),   32'd1);
    check("arst_valid_o", 32'(valid_o_a[0]), 32'd0);
    check("arst_data_o",  32'(dout_a[0]),    32'd0);
    model_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h9A, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_src_fifo.md
# cdc_src_fifo

Single-clock valid/ready FIFO placed directly in front of the two-phase CDC source half, `cdc_2phase_src`, in the source clock domain. The crossing accepts at most one item per handshake round trip, several source cycles long. This FIFO absorbs bursts so producers keep one-item-per-cycle throughput until DEPTH items are pending. It has an optional fall-through mode, a synchronous flush and occupancy reporting.

## Interface
Parameters:
- T, logic: payload type, passed through unchanged.
- DEPTH, 4: number of entries, ≥2, need not be a power of two.
- FALL_THROUGH, 1'b0: 1 = an empty FIFO forwards the input combinationally to the output.
- CNT_W, $clog2(DEPTH+1): derived width of usage_o; not to be overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous discard of all contents.
- data_i  in  T  upstream payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  T  downstream payload, to cdc_2phase_src data_i.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- usage_o  out  CNT_W  number of stored entries, 0..DEPTH.
- full_o  out  1  usage_o == DEPTH.
- empty_o  out  1  usage_o == 0.

## Operation
- Push = valid_i && ready_o. Pop = valid_o && ready_i.
- ready_o = !full_o && !flush_i. It depends only on registered state and flush_i, never on ready_i.
- Normal mode (FALL_THROUGH=0):
  - valid_o = !empty_o && !flush_i.
  - data_o = mem[rd_ptr].
- Fall-through mode (FALL_THROUGH=1):
  - valid_o = (!empty_o || valid_i) && !flush_i.
  - data_o = empty_o ? data_i : mem[rd_ptr].
  - If empty, push and pop in the same cycle: the item bypasses storage and usage stays 0.
- Pointers wr_ptr and rd_ptr are each 0..DEPTH-1. Each increments on its event and wraps from DEPTH-1 to 0 explicitly, so non-power-of-two depths work.
- usage is registered:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- Push and pop in the same cycle while full cannot occur, because ready_o=0. Pop proceeds alone.
- Push and pop in the same cycle with usage 1 in normal mode: the pop reads the old entry and the push writes the next slot. usage stays 1.
- Flush:
  - flush_i forces ready_o=0 and valid_o=0, so no handshake completes in that cycle.
  - Next cycle: wr_ptr=rd_ptr=0, usage=0.
  - The flush has the same effect whatever the state.
- Storage mem is reset to '0 and is not cleared by flush.

## Timing
- Reset values: ready_o=1, valid_o=0 (fall-through: follows valid_i), data_o='0 (fall-through: follows data_i), usage_o=0, full_o=0, empty_o=1.
- Normal mode:
  - Push in cycle N → valid_o=1 in N+1.
  - Sustained push/pop throughput is 1 item per cycle.
- Fall-through mode: zero-cycle latency when empty.
- A push in cycle N updates usage_o/full_o in N+1. ready_o drops in the cycle after the DEPTH-th push.
- Reset asserted mid-burst: all contents lost immediately and outputs take their reset values asynchronously.
- data_o is held stable while valid_o=1 && ready_i=0, as the CDC source requires.

## Structure
- No shared package: T is a type parameter and all constants derive locally from DEPTH.
- One flat module. Pointer/usage logic stays inline; no sub-module is warranted.
- Elaboration-time check: DEPTH < 2 → $error.

## Test plan
- Reset, DEPTH=4, normal mode → ready_o=1, valid_o=0, usage_o=0, empty_o=1, data_o=0.
- Push 0xA1,0xA2,0xA3,0xA4 with ready_i=0 → full_o=1, ready_o=0 in cycle 5. Then ready_i=1 → output 0xA1..0xA4 in order on 4 consecutive cycles, ending with empty_o=1.
- DEPTH=3, 10 items streamed with valid_i=ready_i=1 → all 10 in order, pointer wraps at 2→0, usage_o steady at 1 after the first cycle.
- Usage 2, push 0x55 and flush_i=1 in the same cycle → ready_o=0, valid_o=0 in that cycle. Next cycle usage_o=0, empty_o=1, and 0x55 is never output.
- FALL_THROUGH=1, empty, valid_i=1, data_i=0x7E, ready_i=1 → valid_o=1, data_o=0x7E in the same cycle, usage_o stays 0.
- Attached to cdc_2phase_src, whose ready drops for 4 cycles per item, with a random 0/1 valid_i pattern for 200 items → no loss, duplication or reordering, and data_o stable while stalled.
